// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through stream FIFO controller driving a dual-port RAM (A = write, B = read).
// Latency: write at cycle t is visible on rd_valid/rd_data at t+3; 1 word/cycle sustained both sides.
// Backpressure: wr_ready drops when RAM holds WORDS words; rd_ready low stalls reads and fills the 2-entry output buffer.
// Optional high-water mark output (hwm, hwm_clr) enabled by defining DPRAM_FIFO_CTRL_HWM_EN.
module dpram_fifo_ctrl #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 32,
    parameter int WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [31:0]      count,
    output logic             ram_we,
    output logic             ram_oe,
    output logic [31:0]      ram_address,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_we_b,
    output logic             ram_oe_b,
    output logic [31:0]      ram_address_b,
    input  logic [WIDTH-1:0] ram_dout_b
`ifdef DPRAM_FIFO_CTRL_HWM_EN
    ,
    input  logic             hwm_clr,
    output logic [31:0]      hwm
`endif
);

    localparam logic [DEPTH-1:0] LAST    = DEPTH'(WORDS - 1);
    localparam logic [31:0]      WORDS_W = 32'(WORDS);

    logic [DEPTH-1:0] wptr;
    logic [DEPTH-1:0] rptr;
    logic [31:0]      ram_cnt;
    logic             inflight;
    logic [1:0]       buf_cnt;
    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;

    logic             wr_fire;
    logic             pop;
    logic             issue;
    logic [1:0]       kept;

    assign wr_ready = reset && (ram_cnt < WORDS_W);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_valid = (buf_cnt != 2'd0);
    assign pop      = rd_valid && rd_ready;
    assign kept     = buf_cnt - {1'b0, pop};
    // Issue only if the buffer can still take the word when it returns next cycle.
    assign issue    = reset && (ram_cnt != 32'd0) && ((kept + {1'b0, inflight}) < 2'd2);

    assign rd_data       = buf0;
    assign count         = ram_cnt + 32'(inflight) + 32'(buf_cnt);
    assign ram_we        = wr_fire;
    assign ram_oe        = 1'b0;
    assign ram_address   = 32'(wptr);
    assign ram_din       = wr_data;
    assign ram_we_b      = 1'b0;
    assign ram_oe_b      = issue;
    assign ram_address_b = 32'(rptr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= 32'd0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            if (wr_fire) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            if (issue)   rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            ram_cnt  <= ram_cnt + 32'(wr_fire) - 32'(issue);
            inflight <= issue;
            buf_cnt  <= kept + {1'b0, inflight};
        end
    end

    // Head register only changes on a shift or a returning word, so it holds its value when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            if (pop && (buf_cnt == 2'd2)) buf0 <= buf1;
            if (inflight) begin
                if (kept == 2'd0) buf0 <= ram_dout_b;
                else              buf1 <= ram_dout_b;
            end
        end
    end

`ifdef DPRAM_FIFO_CTRL_HWM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           hwm <= 32'd0;
        else if (hwm_clr)     hwm <= 32'd0;
        else if (count > hwm) hwm <= count;
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: two instances (WORDS=1024 and WORDS=1000) with RAM models, queue-based reference.
module tb_dpram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic        hwm_clr = 1'b0;
    logic [31:0] wr_data = 32'd0;

    logic        wr_ready0, rd_valid0, ram_we0, ram_oe0, ram_we_b0, ram_oe_b0;
    logic [31:0] rd_data0, count0, ram_address0, ram_din0, ram_address_b0, ram_dout_b0, hwm0;
    logic        wr_ready1, rd_valid1, ram_we1, ram_oe1, ram_we_b1, ram_oe_b1;
    logic [31:0] rd_data1, count1, ram_address1, ram_din1, ram_address_b1, ram_dout_b1, hwm1;

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DEPTH(10), .WIDTH(32), .WORDS(1024)) u0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_data(wr_data),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0), .count(count0),
        .ram_we(ram_we0), .ram_oe(ram_oe0), .ram_address(ram_address0), .ram_din(ram_din0),
        .ram_we_b(ram_we_b0), .ram_oe_b(ram_oe_b0), .ram_address_b(ram_address_b0),
        .ram_dout_b(ram_dout_b0)
`ifdef DPRAM_FIFO_CTRL_HWM_EN
        , .hwm_clr(hwm_clr), .hwm(hwm0)
`endif
    );

    dpram_fifo_ctrl #(.DEPTH(10), .WIDTH(32), .WORDS(1000)) u1 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
        .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_data(rd_data1), .count(count1),
        .ram_we(ram_we1), .ram_oe(ram_oe1), .ram_address(ram_address1), .ram_din(ram_din1),
        .ram_we_b(ram_we_b1), .ram_oe_b(ram_oe_b1), .ram_address_b(ram_address_b1),
        .ram_dout_b(ram_dout_b1)
`ifdef DPRAM_FIFO_CTRL_HWM_EN
        , .hwm_clr(hwm_clr), .hwm(hwm1)
`endif
    );

    // Dual-port RAMs with registered read; a same-address write returns the old word on port B.
    always @(posedge clk) begin
        if (ram_we0)   mem0[ram_address0[9:0]] <= ram_din0;
        if (ram_oe_b0) ram_dout_b0 <= mem0[ram_address_b0[9:0]];
        if (ram_we1)   mem1[ram_address1[9:0]] <= ram_din1;
        if (ram_oe_b1) ram_dout_b1 <= mem1[ram_address_b1[9:0]];
    end

    task automatic drive(input logic wv, input logic [31:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        hwm_clr = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h1234_5678, 1'b1);
        checks++; if ({wr_ready0, rd_valid0, ram_we0, ram_oe_b0} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {wr_ready0, rd_valid0, ram_we0, ram_oe_b0}); end
        checks++; if (rd_data0 !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data0); end
        checks++; if (count0 !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count0); end
        tick();
        tick();
        checks++; if ({ram_we0, ram_we1, wr_ready1} !== 3'b0) begin errors++; $display("FAIL reset_we_held got %b want 000", {ram_we0, ram_we1, wr_ready1}); end
        checks++; if ({ram_oe0, ram_we_b0} !== 2'b0) begin errors++; $display("FAIL tied_ports got %b want 00", {ram_oe0, ram_we_b0}); end
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0);
        checks++; if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready got %b want 1", wr_ready0); end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 32'hA5A5_A5A5, 1'b1);
        checks++; if (ram_we0 !== 1'b1 || ram_address0 !== 32'd0) begin errors++; $display("FAIL single_write we=%b addr=%0d want 1/0", ram_we0, ram_address0); end
        tick();
        drive(1'b0, 32'd0, 1'b1);
        checks++; if (rd_valid0 !== 1'b0 || count0 !== 32'd1) begin errors++; $display("FAIL single_t1 valid=%b count=%0d want 0/1", rd_valid0, count0); end
        tick();
        checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL single_t2 valid got %b want 0", rd_valid0); end
        tick();
        checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_t3 valid=%b data=%h want 1/a5a5a5a5", rd_valid0, rd_data0); end
        tick();
        checks++; if (count0 !== 32'd0 || rd_valid0 !== 1'b0) begin errors++; $display("FAIL single_after_pop count=%0d valid=%b want 0/0", count0, rd_valid0); end
        checks++; if (rd_data0 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_hold got %h want a5a5a5a5", rd_data0); end
    endtask

    task automatic test_stream();
        int nw, nr, first_rd, bubbles, stalls, addr_err, wrapped, last_wa;
        nw = 0; nr = 0; first_rd = -1; bubbles = 0; stalls = 0; addr_err = 0; wrapped = 0; last_wa = -1;
        do_reset();
        for (int cyc = 0; cyc < 2200 && nr < 2000; cyc++) begin
            drive(nw < 2000, 32'(nw + 1), 1'b1);
            if (nw < 2000 && !wr_ready0) stalls++;
            if (wr_valid && wr_ready0) begin
                if (last_wa >= 0 && int'(ram_address0) != (last_wa + 1) % 1024) addr_err++;
                if (last_wa == 1023 && ram_address0 == 32'd0) wrapped++;
                last_wa = int'(ram_address0);
                nw++;
            end
            if (rd_valid0 && rd_ready) begin
                if (first_rd < 0) first_rd = cyc;
                checks++; if (rd_data0 !== 32'(nr + 1)) begin errors++; $display("FAIL stream_data got %0d want %0d", rd_data0, nr + 1); end
                nr++;
            end else if (nr > 0) begin
                bubbles++;
            end
            tick();
        end
        checks++; if (nr !== 2000) begin errors++; $display("FAIL stream_count got %0d want 2000", nr); end
        checks++; if (first_rd !== 3) begin errors++; $display("FAIL stream_latency got %0d want 3", first_rd); end
        checks++; if (bubbles !== 0 || stalls !== 0) begin errors++; $display("FAIL stream_bubbles got %0d/%0d want 0/0", bubbles, stalls); end
        checks++; if (addr_err !== 0 || wrapped !== 1) begin errors++; $display("FAIL stream_wrap err=%0d wraps=%0d want 0/1", addr_err, wrapped); end
    endtask

    task automatic test_full();
        int acc, nr, bad, got;
        logic stopped;
        acc = 0; nr = 0; bad = 0; got = 0; stopped = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            drive(1'b1, 32'(acc + 1), 1'b0);
            if (!wr_ready0) begin stopped = 1'b1; break; end
            acc++;
            tick();
        end
        checks++; if (stopped !== 1'b1 || acc !== 1026) begin errors++; $display("FAIL full_accepted got %0d stopped=%b want 1026", acc, stopped); end
        checks++; if (count0 !== 32'd1026) begin errors++; $display("FAIL full_count got %0d want 1026", count0); end
        for (int k = 0; k < 3; k++) begin
            if (wr_ready0 || ram_we0) bad++;
            tick();
            drive(1'b1, 32'hDEAD_0000, 1'b0);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_blocked got %0d writes want 0", bad); end
        drive(1'b0, 32'd0, 1'b1);
        checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== 32'd1) begin errors++; $display("FAIL full_pop valid=%b data=%0d want 1/1", rd_valid0, rd_data0); end
        tick();
        for (int k = 1; k <= 2; k++) begin
            drive(1'b1, 32'd1027, 1'b0);
            if (wr_ready0) begin got = k; tick(); break; end
            tick();
        end
        checks++; if (got == 0) begin errors++; $display("FAIL full_reopen got none want ready within 2"); end
        drive(1'b0, 32'd0, 1'b0);
        checks++; if (count0 !== 32'd1026) begin errors++; $display("FAIL full_refill got %0d want 1026", count0); end
        for (int cyc = 0; cyc < 1300 && nr < 1026; cyc++) begin
            drive(1'b0, 32'd0, 1'b1);
            if (rd_valid0) begin
                checks++; if (rd_data0 !== 32'(nr + 2)) begin errors++; $display("FAIL full_drain got %0d want %0d", rd_data0, nr + 2); end
                nr++;
            end
            tick();
        end
        checks++; if (nr !== 1026 || count0 !== 32'd0) begin errors++; $display("FAIL full_drain_done got %0d count=%0d want 1026/0", nr, count0); end
    endtask

    task automatic test_random_w1000();
        logic [31:0] q[$];
        int nw, nr, viol, cnt_err, wraps, last_wa;
        logic wv, rr;
        nw = 0; nr = 0; viol = 0; cnt_err = 0; wraps = 0; last_wa = -1;
        do_reset();
        for (int cyc = 0; cyc < 20000 && nr < 2500; cyc++) begin
            wv = (nw < 2500) && ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            drive(wv, $urandom, rr);
            if (count1 !== 32'(q.size())) cnt_err++;
            if (ram_we1 && ram_address1 > 32'd999) viol++;
            if (ram_oe_b1 && ram_address_b1 > 32'd999) viol++;
            if (rd_valid1 && rd_ready) begin
                checks++; if (q.size() == 0 || rd_data1 !== q[0]) begin errors++; $display("FAIL rand_data got %h want %h", rd_data1, (q.size() == 0) ? 32'hx : q[0]); end
                if (q.size() != 0) void'(q.pop_front());
                nr++;
            end
            if (wr_valid && wr_ready1) begin
                if (last_wa == 999 && ram_address1 == 32'd0) wraps++;
                last_wa = int'(ram_address1);
                q.push_back(wr_data);
                nw++;
            end
            tick();
        end
        checks++; if (nr !== 2500 || q.size() != 0) begin errors++; $display("FAIL rand_total got %0d left=%0d want 2500/0", nr, q.size()); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rand_addr_range got %0d want 0", viol); end
        checks++; if (cnt_err !== 0) begin errors++; $display("FAIL rand_count got %0d bad cycles want 0", cnt_err); end
        checks++; if (wraps < 2) begin errors++; $display("FAIL rand_wrap got %0d want >=2", wraps); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] got[$];
        logic found;
        found = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(cyc < 5, 32'(100 + cyc), 1'b1);
            found = ram_oe_b0 && (cyc >= 2);
            tick();
            if (found) break;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_issue got none want read issue"); end
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; rd_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({wr_ready0, rd_valid0, ram_we0, ram_oe_b0} !== 4'b0) begin errors++; $display("FAIL mid_ctrl got %b want 0000", {wr_ready0, rd_valid0, ram_we0, ram_oe_b0}); end
        checks++; if (rd_data0 !== 32'd0 || count0 !== 32'd0) begin errors++; $display("FAIL mid_data data=%h count=%0d want 0/0", rd_data0, count0); end
        checks++; if (ram_address0 !== 32'd0 || ram_address_b0 !== 32'd0) begin errors++; $display("FAIL mid_addr a=%0d b=%0d want 0/0", ram_address0, ram_address_b0); end
        tick();
        reset = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(cyc < 2, 32'(7 + cyc), 1'b1);
            if (rd_valid0) got.push_back(rd_data0);
            tick();
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL mid_words got %0d want 2", got.size()); end
        checks++; if (got.size() < 2 || got[0] !== 32'd7 || got[1] !== 32'd8) begin errors++; $display("FAIL mid_order got %0d,%0d want 7,8", (got.size() > 0) ? got[0] : 32'd0, (got.size() > 1) ? got[1] : 32'd0); end
        checks++; if (count0 !== 32'd0) begin errors++; $display("FAIL mid_final_count got %0d want 0", count0); end
    endtask

`ifdef DPRAM_FIFO_CTRL_HWM_EN
    task automatic test_hwm();
        int nw;
        nw = 0;
        do_reset();
        for (int cyc = 0; cyc < 400 && nw < 300; cyc++) begin
            drive(1'b1, 32'(nw), 1'b0);
            if (wr_ready0) nw++;
            tick();
        end
        for (int cyc = 0; cyc < 400 && count0 != 32'd0; cyc++) begin
            drive(1'b0, 32'd0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0);
        tick();
        checks++; if (hwm0 !== 32'd300) begin errors++; $display("FAIL hwm_peak got %0d want 300", hwm0); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'(k), 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0);
        tick();
        tick();
        checks++; if (count0 !== 32'd5) begin errors++; $display("FAIL hwm_count got %0d want 5", count0); end
        hwm_clr = 1'b1;
        tick();
        hwm_clr = 1'b0;
        tick();
        checks++; if (hwm0 !== 32'd5) begin errors++; $display("FAIL hwm_clr got %0d want 5", hwm0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_random_w1000();
        test_reset_midstream();
`ifdef DPRAM_FIFO_CTRL_HWM_EN
        test_hwm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the team's dual-port RAM and turns it into a first-word-fall-through stream FIFO.
- Write side drives RAM port A; read side drives RAM port B.
- A 2-entry output buffer absorbs the RAM's 1-cycle registered read latency, so rd_valid/rd_ready runs at full throughput.
- Used wherever a kernel streams through an on-chip memory, e.g. method-to-method channels.

Parameters:
- DEPTH, 10, RAM address bits actually decoded.
- WIDTH, 32, data word width.
- WORDS, 1024, RAM capacity in words; any value 2..2^DEPTH, not necessarily a power of two.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  controller accepts a word this cycle.
- wr_data  in  WIDTH  write word.
- rd_valid  out  1  rd_data holds the oldest word.
- rd_ready  in  1  consumer takes rd_data this cycle.
- rd_data  out  WIDTH  oldest word, registered.
- count  out  32  total words held (RAM + in-flight + output buffer).
- ram_we  out  1  to RAM we.
- ram_oe  out  1  to RAM oe, tied 0.
- ram_address  out  32  to RAM address; upper bits zero.
- ram_din  out  WIDTH  to RAM din.
- ram_we_b  out  1  to RAM we_b, tied 0.
- ram_oe_b  out  1  to RAM oe_b; read issue strobe.
- ram_address_b  out  32  to RAM address_b.
- ram_dout_b  in  WIDTH  from RAM dout_b; valid the cycle after ram_oe_b.

Behaviour:
- Reset (reset=0, asynchronous):
  - wptr, rptr, ram_cnt, inflight and buffer count clear to 0.
  - wr_ready=0, rd_valid=0, rd_data=0, count=0.
  - ram_we and ram_oe_b are forced to 0 while reset is low.
  - Any in-flight read is discarded. RAM contents are not cleared.
- Write:
  - wr_ready = (ram_cnt < WORDS).
  - On wr_valid && wr_ready, combinationally: ram_we=1, ram_address=wptr, ram_din=wr_data.
  - At the clock edge wptr advances; wptr wraps WORDS-1 -> 0.
  - The word becomes read-eligible (ram_cnt incremented) from the next cycle. The RAM commits at that edge, so there is no same-cycle write/read hazard.
- Read issue:
  - ram_oe_b=1 when ram_cnt > 0 and (buf_cnt + inflight) < 2, taking buf_cnt after this cycle's pop.
  - ram_address_b=rptr. At the edge rptr advances with the same wrap rule, ram_cnt decrements and inflight is set.
  - The RAM slot frees at issue. A port-A write to the same address in the same cycle is legal because port B returns the old word.
- Return:
  - The cycle after issue, ram_dout_b is pushed into the output buffer and inflight clears.
  - The buffer is a 2-entry FIFO; rd_data is always the head register.
- Pop:
  - On rd_valid && rd_ready the head is removed; the second entry (or a simultaneously returning word, if the buffer is empty after the pop) moves to head the same edge.
  - Sustained throughput is 1 word/cycle on both sides.
- Empty-to-valid latency: a write at cycle t gives rd_valid=1 at cycle t+3 (eligible t+1, issued t+1, returned t+2, visible after edge, i.e. t+3).
- Simultaneous push and pop:
  - ram_cnt changes by +1-1 = 0.
  - count = ram_cnt + inflight + buf_cnt, always ≤ WORDS+2.
- Full: ram_cnt==WORDS -> wr_ready=0. Words in the output buffer do not block writes.
- Empty: rd_valid=0; rd_data holds its last value.
- rd_ready with rd_valid=0 is ignored. wr_valid with wr_ready=0 has no effect and no RAM write.

Optional Feature:
- Macro: DPRAM_FIFO_CTRL_HWM_EN.
- When defined: extra output port hwm [31:0], a high-water mark of count.
  - Updated each cycle to max(hwm, count).
  - Cleared by reset.
  - Also cleared synchronously when input hwm_clr=1; hwm_clr wins over the update that cycle.
- When undefined: neither hwm nor hwm_clr exists, and there is no associated logic.

Test Plan:
- Single write of 0xA5A5A5A5 into an empty FIFO at cycle t, rd_ready=1 -> rd_valid rises at t+3 with rd_data=0xA5A5A5A5; count returns to 0 after the pop.
- Stream 1..2000 with wr_valid=1 and rd_ready=1 constantly (WORDS=1024) -> output 1..2000 in order, no bubbles after the initial latency, ram_address wraps 1023 -> 0.
- rd_ready=0, write until wr_ready=0 -> exactly 1026 words accepted (1024 RAM + 2 buffer), count=1026; one pop re-raises wr_ready within 2 cycles.
- WORDS=1000, DEPTH=10, 2500 words with random valid/ready -> order preserved, ram_address never exceeds 999.
- Assert reset low mid-stream with a read in flight -> all outputs 0 immediately; after release, new words 7,8 read back as 7,8 with no stale data.
- With DPRAM_FIFO_CTRL_HWM_EN: fill to 300, drain, hwm=300; pulse hwm_clr with count=5 -> hwm=5 next cycle.
